// File: rtl/dmem_sram_ctrl.sv
// Data-memory controller: turns one-cycle 32-bit MEM-stage loads/stores into
// two timed halfword phases (low then high) on an external 16-bit async SRAM.
module dmem_sram_ctrl #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [31:0]          r_wdata;
    logic                 r_is_wr;

    logic [31:0]          w_offset;
    logic [SRAM_AW-2:0]   w_word_idx;
    logic                 w_req;
    logic                 w_last;
    logic                 w_unused_bits;

    // Base-relative byte offset wraps modulo 2^32; only the word index is kept.
    assign w_offset      = address - ADDR_BASE;
    assign w_word_idx    = w_offset[SRAM_AW:2];
    assign w_unused_bits = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};
    assign w_req         = rd_en | wr_en;
    assign w_last        = (r_cnt == LAST_CNT);

    // Ready feeds the pipeline freeze directly, so it cannot wait a cycle.
    always_comb begin
        ready = 1'b0;
        case (r_state)
            S_IDLE:  ready = ~w_req;
            S_DONE:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Access sequencer with registered SRAM-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_wdata     <= 32'd0;
            r_is_wr     <= 1'b0;
            rdata       <= 32'd0;
            sram_addr   <= '0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // A simultaneous read+write request is treated as a write.
                        r_state     <= S_LO;
                        r_cnt       <= 4'd0;
                        r_wdata     <= wdata;
                        r_is_wr     <= wr_en;
                        sram_addr   <= {w_word_idx, 1'b0};
                        sram_dq_out <= wdata[15:0];
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                    end
                end
                S_LO: begin
                    if (w_last) begin
                        if (!r_is_wr) begin
                            rdata[15:0] <= sram_dq_in;
                        end
                        r_state     <= S_HI;
                        r_cnt       <= 4'd0;
                        sram_addr   <= {sram_addr[SRAM_AW-1:1], 1'b1};
                        sram_dq_out <= r_wdata[31:16];
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_HI: begin
                    if (w_last) begin
                        if (!r_is_wr) begin
                            rdata[31:16] <= sram_dq_in;
                        end
                        r_state    <= S_DONE;
                        r_cnt      <= 4'd0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl: a WAIT_CYCLES=2 instance on a small SRAM
// model, plus a WAIT_CYCLES=1 instance reading a preloaded SRAM.
module tb_dmem_sram_ctrl;

    localparam int W = 2;

    logic        clk;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, wdata, rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        rd_en2, wr_en2;
    logic [31:0] address2, wdata2, rdata2;
    logic        ready2;
    logic [17:0] sram_addr2;
    logic [15:0] sram_dq_out2, sram_dq_in2;
    logic        sram_dq_oe2, sram_we_n2;

    logic [15:0] mem  [0:255];
    logic [15:0] mem2 [0:255];

    int checks = 0;
    int errors = 0;

    dmem_sram_ctrl #(.ADDR_BASE(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    dmem_sram_ctrl #(.ADDR_BASE(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .rd_en(rd_en2), .wr_en(wr_en2),
        .address(address2), .wdata(wdata2), .rdata(rdata2), .ready(ready2),
        .sram_addr(sram_addr2), .sram_dq_out(sram_dq_out2), .sram_dq_in(sram_dq_in2),
        .sram_dq_oe(sram_dq_oe2), .sram_we_n(sram_we_n2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM models: combinational read, write while strobe is low.
    assign sram_dq_in  = mem[sram_addr[7:0]];
    assign sram_dq_in2 = mem2[sram_addr2[7:0]];
    always @(posedge clk) begin
        if (sram_we_n === 1'b0 && sram_dq_oe === 1'b1)
            mem[sram_addr[7:0]] <= sram_dq_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rd_en = 1'b0;
        wr_en = 1'b0;
        next_cycle();
    endtask

    // Issue one request in the current IDLE cycle and follow it to DONE.
    task automatic access(input string tag, input logic r, input logic w,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [17:0] lo_half, input logic [31:0] exp_rd);
        logic [17:0] exp_addr;
        rd_en   = r;
        wr_en   = w;
        address = addr;
        wdata   = wd;
        #1;
        check({tag, "_c0_ready"}, {31'd0, ready}, 32'd0);
        for (int c = 1; c <= 2 * W; c++) begin
            next_cycle();
            exp_addr = (c > W) ? (lo_half | 18'd1) : lo_half;
            check({tag, "_ready"}, {31'd0, ready}, 32'd0);
            check({tag, "_addr"}, {14'd0, sram_addr}, {14'd0, exp_addr});
            check({tag, "_we_n"}, {31'd0, sram_we_n}, {31'd0, ~w});
            check({tag, "_oe"}, {31'd0, sram_dq_oe}, {31'd0, w});
            if (w)
                check({tag, "_dq_out"}, {16'd0, sram_dq_out},
                      (c > W) ? {16'd0, wd[31:16]} : {16'd0, wd[15:0]});
        end
        next_cycle();
        check({tag, "_done_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_rdata"}, rdata, exp_rd);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 16'h0000;
            mem2[i] = 16'h0000;
        end
        mem2[4] = 16'h5678;
        mem2[5] = 16'h1234;

        rst = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; wdata = 32'd0;
        rd_en2 = 1'b0; wr_en2 = 1'b0; address2 = 32'd0; wdata2 = 32'd0;
        next_cycle();
        next_cycle();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        rst = 1'b0;
        next_cycle();

        // Write then read back at the base address.
        access("wr1024", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 32'd0);
        idle();
        access("rd1024", 1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF);
        idle();

        // Address mapping: 1028 -> halves 2/3, 1276 -> halves 126/127.
        access("wr1028", 1'b0, 1'b1, 32'd1028, 32'h11112222, 18'd2, 32'hDEADBEEF);
        idle();
        access("wr1276", 1'b0, 1'b1, 32'd1276, 32'h33334444, 18'd126, 32'hDEADBEEF);
        idle();
        access("rd1028", 1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'h11112222);
        idle();
        access("rd1276", 1'b1, 1'b0, 32'd1276, 32'd0, 18'd126, 32'h33334444);
        idle();

        // No request: ready stays high and no write strobe.
        for (int i = 0; i < 3; i++) begin
            check("idle_ready", {31'd0, ready}, 32'd1);
            check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
            next_cycle();
        end

        // Both enables high behaves as a write; rdata untouched.
        access("both1032", 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 18'd4, 32'h33334444);
        idle();
        access("rd1032", 1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 32'hA5A5A5A5);
        idle();

        // Back-to-back with requests held between accesses.
        access("b2b_rd1", 1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF);
        next_cycle();
        access("b2b_wr", 1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 18'd6, 32'hDEADBEEF);
        next_cycle();
        access("b2b_rd2", 1'b1, 1'b0, 32'd1036, 32'd0, 18'd6, 32'h0BADF00D);
        idle();

        // Reset in the HI phase of a write abandons it.
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1040; wdata = 32'h12345678;
        next_cycle();
        next_cycle();
        next_cycle();
        check("mid_hi_addr", {14'd0, sram_addr}, 32'd9);
        check("mid_hi_we_n", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1;
        next_cycle();
        check("rstm_ready_req", {31'd0, ready}, 32'd0);
        check("rstm_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rstm_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rstm_rdata", rdata, 32'd0);
        rst = 1'b0;
        wr_en = 1'b0;
        #1;
        check("rstm_ready_noreq", {31'd0, ready}, 32'd1);
        next_cycle();
        check("rstm_idle_we_n", {31'd0, sram_we_n}, 32'd1);

        // WAIT_CYCLES=1 instance: read at 1032 (halves 4/5), DONE in cycle 3.
        rd_en2 = 1'b1; address2 = 32'd1032;
        #1;
        check("w1_c0_ready", {31'd0, ready2}, 32'd0);
        next_cycle();
        check("w1_c1_ready", {31'd0, ready2}, 32'd0);
        check("w1_c1_addr", {14'd0, sram_addr2}, 32'd4);
        next_cycle();
        check("w1_c2_ready", {31'd0, ready2}, 32'd0);
        check("w1_c2_addr", {14'd0, sram_addr2}, 32'd5);
        next_cycle();
        check("w1_c3_ready", {31'd0, ready2}, 32'd1);
        check("w1_c3_rdata", rdata2, 32'h12345678);
        rd_en2 = 1'b0;
        next_cycle();
        check("w1_idle_ready", {31'd0, ready2}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_sram_ctrl.md
Name: dmem_sram_ctrl

Overview:
- Sequences 32-bit data-memory accesses from the pipeline MEM stage onto an external 16-bit-wide asynchronous SRAM.
- Each word access takes two halfword phases: low half first, then high half.
- Drives a combinational ready; the hazard/freeze logic uses ~ready to stall every pipeline register while an access is in flight.
- Replaces the single-cycle on-chip data array. Applies the same address mapping: byte address minus base, word-aligned.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM address width in halfword units.
- WAIT_CYCLES, 2: cycles per halfword phase; legal range is 1 to 15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset (see Behaviour).
- rd_en  in  1  MEM-stage read request (MEM_R_EN).
- wr_en  in  1  MEM-stage write request (MEM_W_EN).
- address  in  32  byte address, from the ALU result.
- wdata  in  32  store data, from reg2.
- rdata  out  32  load data; valid while ready=1 in DONE.
- ready  out  1  access complete / no access; freeze = ~ready.
- sram_addr  out  SRAM_AW  halfword address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  controller drives the DQ bus.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. rst has priority over everything.
  - State goes to IDLE; counter to 0.
  - rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - A reset mid-access abandons the access immediately; a partially written word is allowed.
- Address mapping:
  - word_idx = (address - ADDR_BASE)[SRAM_AW:2], computed modulo 2^32 and then truncated.
  - Addresses below ADDR_BASE wrap; no error is flagged.
  - Low half is at sram_addr = {word_idx, 1'b0}; high half at {word_idx, 1'b1}.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en).
  - On a request, latch address, wdata and the operation, then go to LO with cnt=0.
  - If rd_en and wr_en are both high, the access is a write; rdata is not updated.
- LO and HI:
  - Each lasts exactly WAIT_CYCLES cycles; cnt counts 0 to WAIT_CYCLES-1.
  - On the last cycle, LO goes to HI and HI goes to DONE.
  - sram_addr is registered and stable for the whole phase.
  - Write: sram_dq_oe=1 and sram_we_n=0 for every cycle of the phase. sram_dq_out is wdata[15:0] in LO and wdata[31:16] in HI.
  - Read: sram_dq_oe=0, sram_we_n=1. On the last phase cycle, sram_dq_in is captured into rdata[15:0] (LO) or rdata[31:16] (HI).
  - ready=0 throughout.
- DONE:
  - Lasts one cycle with ready=1, and goes to IDLE unconditionally.
  - rdata holds the assembled word from DONE until the next read's LO capture.
- Latency:
  - Request seen in IDLE at cycle 0 means DONE at cycle 2*WAIT_CYCLES+1.
  - ready is low for 2*WAIT_CYCLES+1 cycles; with WAIT_CYCLES=2, ready is low for cycles 0–4 and high in cycle 5.
- Back-to-back requests: after DONE there is one IDLE cycle with ready=0 before the next LO. Requests are never merged.
- Request inputs are ignored outside IDLE, since the frozen pipeline holds them stable. A request dropping mid-access does not abort it.

Test Plan:
1. Write then read, WAIT_CYCLES=2:
   - Write address=1024, wdata=0xDEADBEEF: ready low cycles 0–4.
   - Expect sram_addr=0 with dq_out=0xBEEF in cycles 1–2, then sram_addr=1 with dq_out=0xDEAD in cycles 3–4; we_n=0 in cycles 1–4.
   - Read address=1024: rdata=0xDEADBEEF with ready=1 in DONE.
2. Address mapping:
   - Write 0x11112222 at 1028 and 0x33334444 at 1276.
   - Expect sram_addr halves {2,3} and {126,127}.
   - Read back each word: exact values.
3. Idle and combined requests:
   - rd_en=wr_en=0: ready=1 and we_n=1 constantly.
   - rd_en=wr_en=1 with wdata=0xA5A5A5A5: a write occurs; rdata keeps its prior value.
4. Back-to-back:
   - Read, then an immediate write, then a read, with requests held.
   - Expect exactly one ready=1 cycle per access, separated by 2*WAIT_CYCLES+1 low cycles, and correct data.
5. Reset mid-access:
   - Assert rst in HI of a write.
   - Next cycle: IDLE, we_n=1, dq_oe=0, rdata=0, and ready=~(rd_en|wr_en).
6. WAIT_CYCLES=1 build:
   - Read of a preloaded word: ready high on cycle 3, data correct.
